// File: rtl/fp16_operand_packer.sv
// Packs a little-endian byte stream into a pair of FP16 operands (A then B).
// Partial frames are dropped after TIMEOUT idle cycles so a lost byte cannot misalign later pairs.
module fp16_operand_packer #(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_vld,
    output logic [15:0] o_a,
    output logic [15:0] o_b,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        A_LO = 3'd0,
        A_HI = 3'd1,
        B_LO = 3'd2,
        B_HI = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       a_lo_q, a_lo_d;
    logic [7:0]       a_hi_q, a_hi_d;
    logic [7:0]       b_lo_q, b_lo_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             busy;

    assign busy = (state_q == A_HI) || (state_q == B_LO) || (state_q == B_HI);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        a_lo_d    = a_lo_q;
        a_hi_d    = a_hi_q;
        b_lo_d    = b_lo_q;
        a_d       = a_q;
        b_d       = b_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            A_LO: begin
                if (i_byte_vld) begin
                    a_lo_d  = i_byte;
                    state_d = A_HI;
                end
            end
            A_HI: begin
                if (i_byte_vld) begin
                    a_hi_d  = i_byte;
                    state_d = B_LO;
                end
            end
            B_LO: begin
                if (i_byte_vld) begin
                    b_lo_d  = i_byte;
                    state_d = B_HI;
                end
            end
            B_HI: begin
                if (i_byte_vld) begin
                    a_d     = {a_hi_q, a_lo_q};
                    b_d     = {i_byte, b_lo_q};
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Bytes are never buffered here, even in the transfer cycle.
                overrun_d = i_byte_vld;
                if (i_rdy) begin
                    state_d = A_LO;
                end
            end
            default: state_d = A_LO;
        endcase

        // Idle gap inside a frame: count, and abandon the frame once the gap is too long.
        if (busy && !i_byte_vld) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = A_LO;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= A_LO;
            cnt_q     <= '0;
            a_lo_q    <= '0;
            a_hi_q    <= '0;
            b_lo_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_lo_q    <= a_lo_d;
            a_hi_q    <= a_hi_d;
            b_lo_q    <= b_lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_a       = a_q;
    assign o_b       = b_q;
    assign o_vld     = (state_q == HOLD);
    assign o_busy    = busy;
    assign o_overrun = overrun_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_fp16_operand_packer.sv
// Bench for fp16_operand_packer (TIMEOUT=8): scenario tasks plus a scoreboard that checks
// every accepted pair against the value queued when its frame was driven.
module tb_fp16_operand_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] a, b;
    logic        vld, busy, ovr, tmo;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp16_operand_packer #(.TIMEOUT(8), .CNT_W(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_byte     (din),
        .i_byte_vld (din_vld),
        .o_a        (a),
        .o_b        (b),
        .o_vld      (vld),
        .i_rdy      (rdy),
        .o_busy     (busy),
        .o_overrun  (ovr),
        .o_timeout  (tmo)
    );

    // Scoreboard: a transfer happens on the next rising edge when o_vld && i_rdy here.
    always @(negedge clk) begin
        if (rst_n && vld && rdy) begin
            xfers++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got a=%h b=%h, required no transfer", a, b);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({a, b} !== e) begin
                    bad++;
                    $display("FAIL xfer_pair: got a=%h b=%h, required a=%h b=%h", a, b, e[31:16], e[15:0]);
                end else begin
                    $display("xfer a=%h b=%h ok", a, b);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives four bytes on consecutive cycles starting now; returns just after the 4th is sampled.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input bit push);
        logic [7:0] bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        if (push) exp_q.push_back({b1, b0, b3, b2});
        for (int i = 0; i < 4; i++) begin
            din = bytes[i];
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        total++;
        if ({a, b, vld, busy, ovr, tmo} !== 36'h0) begin
            bad++;
            $display("FAIL reset_state: got a=%h b=%h vld=%b busy=%b ovr=%b tmo=%b, required all 0",
                     a, b, vld, busy, ovr, tmo);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        rdy = 1'b1;
        send_frame(8'h00, 8'h3C, 8'h00, 8'h40, 1'b1);
        total++;
        if (vld !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_vld_rise: got vld=%b busy=%b, required vld=1 busy=0", vld, busy);
        end
        tick();
        total++;
        if (vld !== 1'b0 || a !== 16'h3C00 || b !== 16'h4000) begin
            bad++;
            $display("FAIL basic_after: got vld=%b a=%h b=%h, required vld=0 a=3c00 b=4000", vld, a, b);
        end
        tick();
    endtask

    task automatic test_backpressure;
        int x0;
        int high;
        x0 = xfers;
        high = 0;
        rdy = 1'b0;
        send_frame(8'h55, 8'h3A, 8'hAA, 8'hC1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (vld === 1'b1 && a === 16'h3A55 && b === 16'hC1AA) high++;
            if (i == 10) rdy = 1'b1;
            tick();
        end
        total++;
        if (high != 11 || vld !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_hold: got %0d stable vld cycles, vld now=%b, required 11 and 0", high, vld);
        end
        total++;
        if (xfers - x0 != 1) begin
            bad++;
            $display("FAIL backpressure_xfers: got %0d transfers, required 1", xfers - x0);
        end
    endtask

    task automatic test_overrun;
        rdy = 1'b0;
        send_frame(8'h34, 8'h12, 8'h78, 8'h56, 1'b1);
        din = 8'hFF;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        total++;
        if (ovr !== 1'b1 || vld !== 1'b1 || b !== 16'h5678 || a !== 16'h1234) begin
            bad++;
            $display("FAIL overrun_hold: got ovr=%b vld=%b a=%h b=%h, required 1 1 1234 5678", ovr, vld, a, b);
        end
        tick();
        total++;
        if (ovr !== 1'b0) begin
            bad++;
            $display("FAIL overrun_pulse_end: got ovr=%b, required 0", ovr);
        end
        // Byte strobed in the transfer cycle must also be dropped.
        rdy = 1'b1;
        din = 8'hAB;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        total++;
        if (ovr !== 1'b1 || vld !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_xfer: got ovr=%b vld=%b busy=%b, required 1 0 0", ovr, vld, busy);
        end
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        total++;
        if (vld !== 1'b1 || a !== 16'h0201 || b !== 16'h0403) begin
            bad++;
            $display("FAIL overrun_realign: got vld=%b a=%h b=%h, required 1 0201 0403", vld, a, b);
        end
        tick();
    endtask

    task automatic test_timeout;
        int early;
        early = 0;
        rdy = 1'b1;
        din = 8'h99; din_vld = 1'b1; tick();
        din = 8'h88; tick();
        din_vld = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (tmo !== 1'b0 || busy !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL timeout_early: got %0d bad idle cycles, required 0", early);
        end
        tick();
        total++;
        if (tmo !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire: got tmo=%b busy=%b, required 1 0", tmo, busy);
        end
        tick();
        total++;
        if (tmo !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_end: got tmo=%b, required 0", tmo);
        end
        send_frame(8'h01, 8'h80, 8'hFF, 8'h7B, 1'b1);
        total++;
        if (vld !== 1'b1 || a !== 16'h8001 || b !== 16'h7BFF) begin
            bad++;
            $display("FAIL timeout_next_frame: got vld=%b a=%h b=%h, required 1 8001 7bff", vld, a, b);
        end
        tick();
    endtask

    task automatic test_boundary;
        int seen;
        seen = 0;
        rdy = 1'b1;
        din = 8'h11; din_vld = 1'b1; tick();
        din_vld = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (tmo !== 1'b0) seen++;
        end
        exp_q.push_back({8'h22, 8'h11, 8'h44, 8'h33});
        din = 8'h22; din_vld = 1'b1; tick();
        total++;
        if (tmo !== 1'b0 || busy !== 1'b1 || seen != 0) begin
            bad++;
            $display("FAIL boundary_accept: got tmo=%b busy=%b early=%0d, required 0 1 0", tmo, busy, seen);
        end
        din = 8'h33; tick();
        din = 8'h44; tick();
        din_vld = 1'b0;
        total++;
        if (vld !== 1'b1 || a !== 16'h2211 || b !== 16'h4433) begin
            bad++;
            $display("FAIL boundary_frame: got vld=%b a=%h b=%h, required 1 2211 4433", vld, a, b);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        send_frame(8'hC0, 8'hDE, 8'hEF, 8'hBE, 1'b1);
        tick();
        send_frame(8'h0D, 8'hF0, 8'hAD, 8'h0B, 1'b1);
        total++;
        if (vld !== 1'b1 || ovr !== 1'b0 || a !== 16'hF00D || b !== 16'h0BAD) begin
            bad++;
            $display("FAIL b2b_second: got vld=%b ovr=%b a=%h b=%h, required 1 0 f00d 0bad", vld, ovr, a, b);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        rdy = 1'b1;
        din = 8'h10; din_vld = 1'b1; tick();
        din = 8'h20; tick();
        din = 8'h30; tick();
        din_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || vld !== 1'b0 || a !== 16'h0 || b !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_frame: got busy=%b vld=%b a=%h b=%h, required all 0", busy, vld, a, b);
        end
        tick();
        rst_n = 1'b1;
        rdy = 1'b0;
        send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (vld !== 1'b0 || a !== 16'h0 || b !== 16'h0) begin
            bad++;
            $display("FAIL reset_hold: got vld=%b a=%h b=%h, required 0 0000 0000", vld, a, b);
        end
        tick();
        rst_n = 1'b1;
        rdy = 1'b1;
        send_frame(8'h00, 8'hBC, 8'h01, 8'h3C, 1'b1);
        total++;
        if (vld !== 1'b1 || a !== 16'hBC00 || b !== 16'h3C01) begin
            bad++;
            $display("FAIL reset_recover: got vld=%b a=%h b=%h, required 1 bc00 3c01", vld, a, b);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pairs never transferred, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_operand_packer.md
# fp16_operand_packer

Upstream feeder for the FP16 adder datapath. It assembles a little-endian byte stream, typically from a UART receiver, into a pair of FP16 operands. It presents the pair on registered outputs wired directly to the adder's `i_a` / `i_b`, under a valid/ready handshake. Partial frames are discarded after an inter-byte timeout so that a lost byte cannot permanently misalign operands.

## Interface

Reset and clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `TIMEOUT`, default 1000: idle cycles allowed between bytes of one frame before the partial frame is dropped; must be ≥ 2.
- `CNT_W`, default 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_byte`, input, 8: incoming data byte.
- `i_byte_vld`, input, 1: `i_byte` valid for this cycle; single-cycle strobe, no backpressure.
- `o_a`, output, 16: operand A (FP16 bit pattern), to adder `i_a`.
- `o_b`, output, 16: operand B (FP16 bit pattern), to adder `i_b`.
- `o_vld`, output, 1: `o_a` / `o_b` hold a complete pair.
- `i_rdy`, input, 1: consumer accepts the pair when `o_vld && i_rdy`.
- `o_busy`, output, 1: a frame is partially received (states `A_HI`, `B_LO`, `B_HI`).
- `o_overrun`, output, 1: one-cycle pulse when a byte is dropped because a pair is pending.
- `o_timeout`, output, 1: one-cycle pulse when a partial frame is discarded.

## Operation

- Frame format: 4 bytes, in the order A[7:0], A[15:8], B[7:0], B[15:8]. Bit patterns pass through untouched; there is no FP interpretation, and DAZ/FTZ stays in the adder.
- FSM states: `A_LO` (reset state), `A_HI`, `B_LO`, `B_HI`, `HOLD`.
  - `A_LO` -> `A_HI` on `i_byte_vld`; capture the byte into shadow register `a_lo`.
  - `A_HI` -> `B_LO` on `i_byte_vld`; capture into `a_hi`.
  - `B_LO` -> `B_HI` on `i_byte_vld`; capture into `b_lo`.
  - `B_HI` -> `HOLD` on `i_byte_vld`. In the same edge, load `o_a <= {a_hi,a_lo}` and `o_b <= {i_byte,b_lo}`.
  - `HOLD` -> `A_LO` when `i_rdy`.
- Output behaviour:
  - `o_vld` = (state == `HOLD`), registered.
  - `o_a` / `o_b` change only on the `B_HI` capture edge. They remain stable throughout `HOLD` and after the transfer until the next frame completes.
- Overrun:
  - `i_byte_vld` in `HOLD` drops the byte, including in the transfer cycle where `i_rdy` = 1.
  - `o_overrun` = 1 on the following cycle, for 1 cycle.
  - State and outputs are unaffected.
- Timeout counter:
  - Cleared to 0 on every accepted byte.
  - Held at 0 in `A_LO` and `HOLD`.
  - Increments each cycle in `A_HI`, `B_LO`, `B_HI` without `i_byte_vld`.
  - If the counter equals TIMEOUT−1 in such a state and no byte arrives: the next state is `A_LO`, the counter is cleared, and `o_timeout` pulses 1 cycle. The shadow registers are not cleared; they are overwritten by the next frame.
  - A byte arriving in the same cycle the counter reaches TIMEOUT−1 is accepted normally and no timeout occurs.
- Arithmetic: the counter saturates logically via the timeout transition and never wraps.

## Timing

- Reset values:
  - `o_a` = 16'h0000, `o_b` = 16'h0000.
  - `o_vld`, `o_busy`, `o_overrun`, `o_timeout` = 0.
  - State `A_LO`, counter 0, shadow registers 0.
- Reset asserted mid-frame or in `HOLD` aborts immediately. A pending pair is lost and `o_vld` falls asynchronously.
- Latency: 4th byte strobe in cycle N -> `o_vld` = 1 in cycle N+1.
- Throughput: bytes may arrive every cycle. A first byte in the cycle after the transfer (`A_LO`) is accepted.
- Handshake: `o_vld` never drops without `i_rdy`. The transfer completes in the cycle `o_vld && i_rdy`, and `o_vld` = 0 in the next cycle. `i_rdy` held high before `o_vld` gives a 1-cycle `HOLD`.
- Timeout: the last byte is accepted at cycle N. With no further bytes, `o_timeout` = 1 at cycle N+TIMEOUT and `o_busy` = 0 from that cycle.

## Test plan

- **Basic frame.** Reset, then bytes 00,3C,00,40 on consecutive cycles with `i_rdy` = 1 -> `o_vld` = 1 for exactly 1 cycle, one cycle after the 4th byte; `o_a` = 16'h3C00, `o_b` = 16'h4000; outputs stay stable afterwards.
- **Backpressure.** Same frame, `i_rdy` = 0 for 10 cycles then 1 -> `o_vld` high for 11 cycles; `o_a` / `o_b` constant; exactly one transfer.
- **Overrun.** In `HOLD`, strobe byte FF with `i_rdy` = 0 -> `o_overrun` 1-cycle pulse, `o_b` unchanged. Strobe a byte in the transfer cycle -> byte dropped, `o_overrun` pulse, next frame aligns correctly.
- **Timeout.** TIMEOUT = 8. Send 2 bytes, then idle -> `o_timeout` pulse 8 cycles after the 2nd byte, `o_busy` falls. Then frame 01,80,FF,7B -> `o_a` = 16'h8001, `o_b` = 16'h7BFF.
- **Boundary.** TIMEOUT = 8. Send a byte exactly at idle count 7 -> accepted, no `o_timeout`.
- **Reset mid-operation.** Assert `i_rst_n` = 0 after 3 bytes, then separately while in `HOLD` -> all outputs 0 immediately. After release, a fresh 4-byte frame yields the correct pair.
